// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: counts spikes and records the first-spike index over a
// programmable window, then reports both over a valid/ready handshake.
module spike_rate_decoder #(
    parameter int WINDOW_W = 8,
    parameter int COUNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                spike,
    input  logic [WINDOW_W-1:0] window_len,
    output logic [COUNT_W-1:0]  rate,
    output logic [WINDOW_W-1:0] first_spike,
    output logic                valid,
    input  logic                ready,
    output logic                overrun
);

    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [WINDOW_W-1:0] NO_SPIKE = '1;
    localparam logic [WINDOW_W-1:0] ONE      = {{(WINDOW_W-1){1'b0}}, 1'b1};

    state_t              state;
    logic [WINDOW_W-1:0] len_q;
    logic [WINDOW_W-1:0] t_q;
    logic [COUNT_W-1:0]  cnt_q;
    logic [WINDOW_W-1:0] first_q;

    logic [WINDOW_W-1:0] len_in;
    logic [COUNT_W-1:0]  cnt_next;
    logic [WINDOW_W-1:0] first_next;
    logic                win_end;

    always_comb begin
        len_in     = (window_len == '0) ? ONE : window_len;
        cnt_next   = (spike && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
        first_next = (spike && (first_q == NO_SPIKE)) ? t_q : first_q;
        win_end    = (state == COUNT) && enable && (t_q == (len_q - ONE));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_q       <= ONE;
            t_q         <= '0;
            cnt_q       <= '0;
            first_q     <= NO_SPIKE;
            rate        <= '0;
            first_spike <= NO_SPIKE;
            valid       <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        len_q   <= len_in;
                        t_q     <= '0;
                        cnt_q   <= '0;
                        first_q <= NO_SPIKE;
                        state   <= COUNT;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        t_q     <= '0;
                        cnt_q   <= '0;
                        first_q <= NO_SPIKE;
                        state   <= IDLE;
                    end else if (win_end) begin
                        // back-to-back windows: re-latch length, no gap cycle
                        len_q   <= len_in;
                        t_q     <= '0;
                        cnt_q   <= '0;
                        first_q <= NO_SPIKE;
                    end else begin
                        t_q     <= t_q + ONE;
                        cnt_q   <= cnt_next;
                        first_q <= first_next;
                    end
                end
                default: state <= IDLE;
            endcase

            // a simultaneous accept frees the slot for the new result
            if (win_end) begin
                if (!valid || ready) begin
                    rate        <= cnt_next;
                    first_spike <= first_next;
                    valid       <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder; a 4-bit-count instance shares the
// stimulus to exercise saturation.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       spike;
    logic [7:0] window_len;
    logic       ready;
    logic [7:0] rate;
    logic [7:0] first_spike;
    logic       valid;
    logic       overrun;
    logic [3:0] rate4;
    logic [7:0] first4;
    logic       valid4;
    logic       overrun4;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    spike_rate_decoder #(.WINDOW_W(8), .COUNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .spike(spike),
        .window_len(window_len), .rate(rate), .first_spike(first_spike),
        .valid(valid), .ready(ready), .overrun(overrun)
    );

    spike_rate_decoder #(.WINDOW_W(8), .COUNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .spike(spike),
        .window_len(window_len), .rate(rate4), .first_spike(first4),
        .valid(valid4), .ready(ready), .overrun(overrun4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] r,
                             input logic [7:0] f, input logic o);
        check({tag, ".valid"}, 32'(valid), 32'(v));
        if (v) begin
            check({tag, ".rate"}, 32'(rate), 32'(r));
            check({tag, ".first"}, 32'(first_spike), 32'(f));
        end
        check({tag, ".overrun"}, 32'(overrun), 32'(o));
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; spike = 1'b0; window_len = 8'd4; ready = 1'b0;
        step(); step();
        check("rst.valid", 32'(valid), 32'd0);
        check("rst.rate", 32'(rate), 32'd0);
        check("rst.first", 32'(first_spike), 32'd255);
        check("rst.overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;

        // 1: L=4, constant spikes, always ready
        window_len = 8'd4; spike = 1'b1; ready = 1'b1; enable = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1.early_valid", 32'(valid), 32'd0);
        end
        step();
        check_out("t1.win1", 1'b1, 8'd4, 8'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1.gap_valid", 32'(valid), 32'd0);
        end
        step();
        check_out("t1.win2", 1'b1, 8'd4, 8'd0, 1'b0);
        enable = 1'b0; step();

        // 2: L=10, spikes at t=3 and t=7, then an empty window
        window_len = 8'd10; spike = 1'b0; enable = 1'b1;
        step();
        for (int t = 0; t < 10; t++) begin
            spike = (t == 3) || (t == 7);
            step();
            if (t < 9) check("t2.early_valid", 32'(valid), 32'd0);
        end
        check_out("t2.win1", 1'b1, 8'd2, 8'd3, 1'b0);
        spike = 1'b0;
        for (int t = 0; t < 10; t++) step();
        check_out("t2.empty", 1'b1, 8'd0, 8'd255, 1'b0);
        enable = 1'b0; step();

        // 3: L=20 constant spikes; 4-bit counter saturates at 15
        window_len = 8'd20; spike = 1'b1; enable = 1'b1;
        step();
        for (int t = 0; t < 20; t++) step();
        check_out("t3.w8", 1'b1, 8'd20, 8'd0, 1'b0);
        check("t3.valid4", 32'(valid4), 32'd1);
        check("t3.rate4", 32'(rate4), 32'd15);
        check("t3.first4", 32'(first4), 32'd0);
        enable = 1'b0; step();

        // 4: backpressure across two window ends
        window_len = 8'd3; ready = 1'b0; enable = 1'b1;
        step();
        spike = 1'b0; step();
        spike = 1'b1; step();
        spike = 1'b0; step();
        check_out("t4.first", 1'b1, 8'd1, 8'd1, 1'b0);
        spike = 1'b1;
        step(); step(); step();
        check_out("t4.dropped", 1'b1, 8'd1, 8'd1, 1'b1);
        enable = 1'b0; ready = 1'b1;
        step();
        check_out("t4.accept", 1'b0, 8'd0, 8'd0, 1'b1);
        ready = 1'b0;

        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("t5.pre_overrun", 32'(overrun), 32'd0);

        // 5: accept coincides with the next window end
        window_len = 8'd3; enable = 1'b1;
        step();
        spike = 1'b1; step();
        spike = 1'b0; step(); step();
        check_out("t5.winA", 1'b1, 8'd1, 8'd0, 1'b0);
        spike = 1'b0; step();
        spike = 1'b1; step();
        ready = 1'b1; step();
        check_out("t5.simul", 1'b1, 8'd2, 8'd1, 1'b0);
        enable = 1'b0; step();
        check("t5.cleared", 32'(valid), 32'd0);

        // 5b: window_len=0 acts as 1
        window_len = 8'd0; enable = 1'b1; ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            spike = (i != 1);
            step();
            check_out("t5.len0", 1'b1, spike ? 8'd1 : 8'd0, spike ? 8'd0 : 8'd255, 1'b0);
        end
        enable = 1'b0; step();

        // 6: abort mid-window, fresh window, then reset with a pending result
        window_len = 8'd8; spike = 1'b1; enable = 1'b1; ready = 1'b0;
        step();
        for (int t = 0; t < 5; t++) step();
        enable = 1'b0;
        step();
        check("t6.abort_valid", 32'(valid), 32'd0);
        step(); step();
        check("t6.idle_valid", 32'(valid), 32'd0);
        enable = 1'b1;
        step();
        for (int t = 0; t < 8; t++) begin
            spike = (t == 2);
            step();
            if (t < 7) check("t6.fresh_early", 32'(valid), 32'd0);
        end
        check_out("t6.fresh", 1'b1, 8'd1, 8'd2, 1'b0);
        spike = 1'b0;
        for (int t = 0; t < 8; t++) step();
        check_out("t6.ovr", 1'b1, 8'd1, 8'd2, 1'b1);
        step(); step(); step();
        rst_n = 1'b0;
        step();
        check("t6.rst.valid", 32'(valid), 32'd0);
        check("t6.rst.rate", 32'(rate), 32'd0);
        check("t6.rst.first", 32'(first_spike), 32'd255);
        check("t6.rst.overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
